// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32IM pipeline: load/store func3 encodings,
// the memory-access FSM state type and the default responder timeout.
package cpu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mau_state_t;

endpackage

// File: rtl/mem_align_check.sv
// Legality and alignment check for a single load/store request.
// Kept standalone so the exception unit can reuse the same decode.
module mem_align_check
    import cpu_pkg::*;
(
    input  logic       read,
    input  logic       write,
    input  logic [2:0] func3,
    input  logic [1:0] addr_lo,
    output logic       misaligned,
    output logic       illegal
);

    // Decode illegal op/func3 combinations and natural-alignment violations.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (read && write) begin
            illegal = 1'b1;
        end else if (read) begin
            illegal = !(func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end else if (write) begin
            illegal = !(func3 inside {F3_B, F3_H, F3_W});
        end
        if (read || write) begin
            case (func3)
                F3_H, F3_HU: misaligned = addr_lo[0];
                F3_W:        misaligned = (addr_lo != 2'b00);
                default:     misaligned = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the data-memory protocol. Accepts one load/store
// at a time, pulses Read/Write for a single cycle, then waits for busywait
// to fall (or for the timeout) while holding the pipeline.
//
// Handshake: a request is accepted in IDLE when mem_read or mem_write is
// high; the pipeline keeps its inputs stable while stall=1, and the result
// (load_data, fault pulses) is valid in the single cycle where stall drops
// (state DONE). The memory responder sees one Read/Write pulse and signals
// completion by presenting busywait=0 while Address/Func3 are held.
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_WIDTH      = 5
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [2:0]  func3,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        fault_misaligned,
    output logic        fault_timeout,
    output logic        Read,
    output logic        Write,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    output logic [2:0]  Func3,
    input  logic [31:0] Read_data,
    input  logic        busywait,
    output mau_state_t  dbg_state
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    mau_state_t           state;
    mau_state_t           state_next;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 op_load;
    logic                 req;
    logic                 req_misaligned;
    logic                 req_illegal;
    logic                 req_fault;

    assign req       = mem_read | mem_write;
    assign req_fault = req_misaligned | req_illegal;
    assign dbg_state = state;

    mem_align_check u_align (
        .read       (mem_read),
        .write      (mem_write),
        .func3      (func3),
        .addr_lo    (addr[1:0]),
        .misaligned (req_misaligned),
        .illegal    (req_illegal)
    );

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode and combinational stall.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                // Reset gating keeps stall low while Reset is held even if
                // the pipeline still presents a request.
                stall = req & ~Reset;
                if (req) state_next = req_fault ? DONE : ISSUE;
            end
            ISSUE: begin
                stall      = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (!busywait || (wait_cnt == CNT_LAST)) state_next = DONE;
            end
            DONE: begin
                stall      = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latching, strobes, wait counter, load capture and fault pulses.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Read             <= 1'b0;
            Write            <= 1'b0;
            fault_misaligned <= 1'b0;
            fault_timeout    <= 1'b0;
            wait_cnt         <= '0;
            op_load          <= 1'b0;
            load_data        <= '0;
            Address          <= '0;
            Write_data       <= '0;
            Func3            <= '0;
        end else begin
            Read             <= 1'b0;
            Write            <= 1'b0;
            fault_misaligned <= 1'b0;
            fault_timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        Address    <= addr;
                        Write_data <= store_data;
                        Func3      <= func3;
                        op_load    <= mem_read;
                        if (req_fault) begin
                            fault_misaligned <= 1'b1;
                        end else begin
                            Read  <= mem_read;
                            Write <= mem_write;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (!busywait) begin
                        if (op_load) load_data <= Read_data;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_WIDTH'(1);
                        if (wait_cnt == CNT_LAST) fault_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-addressed memory responder
// and an expected-load_data queue checked when each access completes.
module tb_mem_access_unit;
    import cpu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        mem_read, mem_write;
    logic [31:0] addr, store_data;
    logic [2:0]  func3;
    logic        stall;
    logic [31:0] load_data;
    logic        fault_misaligned, fault_timeout;
    logic        Read, Write;
    logic [31:0] Address, Write_data;
    logic [2:0]  Func3;
    logic [31:0] Read_data;
    logic        busywait;
    mau_state_t  dbg_state;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_q[$];

    logic [7:0] mem [0:255];
    bit         mem_loaded = 1'b0;

    mem_access_unit dut (
        .Clock(Clock), .Reset(Reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .store_data(store_data), .func3(func3), .stall(stall),
        .load_data(load_data), .fault_misaligned(fault_misaligned),
        .fault_timeout(fault_timeout), .Read(Read), .Write(Write),
        .Address(Address), .Write_data(Write_data), .Func3(Func3),
        .Read_data(Read_data), .busywait(busywait), .dbg_state(dbg_state)
    );

    // Clock generation.
    always #5 Clock = ~Clock;

    // Memory responder: preload once, then commit stores on the Write pulse.
    always @(posedge Clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'hEF;
            mem[8'h11] <= 8'hBE;
            mem[8'h12] <= 8'hAD;
            mem[8'h13] <= 8'hDE;
            mem_loaded <= 1'b1;
        end else if (Write) begin
            case (Func3)
                F3_B: mem[Address[7:0]] <= Write_data[7:0];
                F3_H: begin
                    mem[Address[7:0]]         <= Write_data[7:0];
                    mem[Address[7:0] + 8'd1]  <= Write_data[15:8];
                end
                F3_W: begin
                    mem[Address[7:0]]         <= Write_data[7:0];
                    mem[Address[7:0] + 8'd1]  <= Write_data[15:8];
                    mem[Address[7:0] + 8'd2]  <= Write_data[23:16];
                    mem[Address[7:0] + 8'd3]  <= Write_data[31:24];
                end
                default: ;
            endcase
        end
    end

    // Combinational read port with sign/zero extension.
    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[Address[7:0]];
        b1 = mem[Address[7:0] + 8'd1];
        b2 = mem[Address[7:0] + 8'd2];
        b3 = mem[Address[7:0] + 8'd3];
        Read_data = 32'h0;
        case (Func3)
            F3_B:  Read_data = {{24{b0[7]}}, b0};
            F3_H:  Read_data = {{16{b1[7]}}, b1, b0};
            F3_W:  Read_data = {b3, b2, b1, b0};
            F3_BU: Read_data = {24'h0, b0};
            F3_HU: Read_data = {16'h0, b1, b0};
            default: Read_data = 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge and follow it to DONE, checking stall
    // length, strobe counts, fault pulses and the scoreboarded load_data.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f3, input int exp_stall,
                          input logic exp_mis, input logic exp_to,
                          input logic [31:0] exp_load);
        int  stall_cnt = 0;
        int  rd_cnt    = 0;
        int  wr_cnt    = 0;
        bit  done      = 1'b0;
        logic strobes;
        strobes = !exp_mis;
        exp_q.push_back(exp_load);
        mem_read = rd; mem_write = wr; addr = a; store_data = d; func3 = f3;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (stall) begin
                stall_cnt++;
                rd_cnt += int'(Read);
                wr_cnt += int'(Write);
                @(negedge Clock);
            end else begin
                done = 1'b1;
            end
        end
        check({tag, "_done_reached"}, 32'(done), 32'd1);
        check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, "_state_done"}, 32'(dbg_state), 32'(DONE));
        check({tag, "_fault_mis"}, 32'(fault_misaligned), 32'(exp_mis));
        check({tag, "_fault_to"}, 32'(fault_timeout), 32'(exp_to));
        check({tag, "_read_pulses"}, 32'(rd_cnt), 32'(rd & strobes));
        check({tag, "_write_pulses"}, 32'(wr_cnt), 32'(wr & strobes));
        check({tag, "_address"}, Address, a);
        check({tag, "_func3"}, 32'(Func3), 32'(f3));
        if (exp_q.size() > 0) check({tag, "_load_data"}, load_data, exp_q.pop_front());
        else check({tag, "_queue_nonempty"}, 32'(exp_q.size()), 32'd1);
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge Clock);
        #1;
        check({tag, "_back_idle"}, 32'(dbg_state), 32'(IDLE));
        check({tag, "_idle_no_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        Reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        addr = '0; store_data = '0; func3 = '0; busywait = 1'b0;
        repeat (3) @(negedge Clock);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_read", 32'(Read), 32'd0);
        check("rst_write", 32'(Write), 32'd0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_address", Address, 32'h0);
        check("rst_faults", 32'({fault_misaligned, fault_timeout}), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        Reset = 1'b0;
        @(negedge Clock);

        access("lw_10",  1, 0, 32'h10, 32'h0,  F3_W,  3, 0, 0, 32'hDEADBEEF);
        access("sb_23",  0, 1, 32'h23, 32'hA5, F3_B,  3, 0, 0, 32'hDEADBEEF);
        check("sb_wdata", Write_data, 32'hA5);
        access("lbu_23", 1, 0, 32'h23, 32'h0,  F3_BU, 3, 0, 0, 32'h000000A5);
        access("lh_12",  1, 0, 32'h12, 32'h0,  F3_H,  3, 0, 0, 32'hFFFFDEAD);
        access("lhu_12", 1, 0, 32'h12, 32'h0,  F3_HU, 3, 0, 0, 32'h0000DEAD);
        access("lb_23",  1, 0, 32'h23, 32'h0,  F3_B,  3, 0, 0, 32'hFFFFFFA5);
        access("lh_21",  1, 0, 32'h21, 32'h0,  F3_H,  1, 1, 0, 32'hFFFFFFA5);
        access("sw_22",  0, 1, 32'h22, 32'h55, F3_W,  1, 1, 0, 32'hFFFFFFA5);
        access("ld_f011",1, 0, 32'h10, 32'h0,  3'b011,1, 1, 0, 32'hFFFFFFA5);
        access("st_f100",0, 1, 32'h10, 32'h0,  F3_BU, 1, 1, 0, 32'hFFFFFFA5);
        access("rd_wr",  1, 1, 32'h10, 32'h0,  F3_W,  1, 1, 0, 32'hFFFFFFA5);

        busywait = 1'b1;
        access("lw_tmo", 1, 0, 32'h10, 32'h0,  F3_W, 18, 0, 1, 32'hFFFFFFA5);
        busywait = 1'b0;
        access("lw_after_tmo", 1, 0, 32'h10, 32'h0, F3_W, 3, 0, 0, 32'hDEADBEEF);

        // Reset while the load is sitting in WAIT.
        busywait = 1'b1;
        mem_read = 1'b1; addr = 32'h10; func3 = F3_W;
        @(negedge Clock);
        @(negedge Clock);
        #2;
        check("mid_wait_state", 32'(dbg_state), 32'(WAIT));
        check("mid_wait_stall", 32'(stall), 32'd1);
        Reset = 1'b1;
        #1;
        check("rst_async_state", 32'(dbg_state), 32'(IDLE));
        check("rst_async_stall", 32'(stall), 32'd0);
        check("rst_async_strobes", 32'({Read, Write}), 32'd0);
        mem_read = 1'b0;
        busywait = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("post_rst_load_data", load_data, 32'h0);
        check("post_rst_address", Address, 32'h0);
        @(negedge Clock);

        access("sw_40", 0, 1, 32'h40, 32'h12345678, F3_W, 3, 0, 0, 32'h0);
        access("lw_40", 1, 0, 32'h40, 32'h0,        F3_W, 3, 0, 0, 32'h12345678);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory protocol; sits in the MEM stage of the RV32IM pipeline between pipeline registers and Data_Memory.
- Turns MEM-stage load/store requests into Read/Write/Address/Write_data/Func3 strobes and waits on busywait.
- Stalls the pipeline while an access is outstanding; returns load data and fault flags.
- Checks alignment and func3 legality before issuing, and times out a stuck responder.

Parameters:
- TIMEOUT_CYCLES, 16, WAIT-state cycles with busywait high before the access is abandoned.
- CNT_WIDTH, 5, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high.
- mem_read  input  1  MEM-stage load request.
- mem_write  input  1  MEM-stage store request.
- addr  input  32  byte address from ALU.
- store_data  input  32  rs2 value.
- func3  input  3  RV32 load/store func3.
- stall  output  1  hold pipeline (combinational).
- load_data  output  32  registered load result.
- fault_misaligned  output  1  one-cycle pulse: misaligned or illegal request.
- fault_timeout  output  1  one-cycle pulse: responder timeout.
- Read  output  1  memory read strobe.
- Write  output  1  memory write strobe.
- Address  output  32  latched address.
- Write_data  output  32  latched store data.
- Func3  output  3  latched func3.
- Read_data  input  32  memory read data, sign/zero-extended by memory.
- busywait  input  1  memory busy.

Behaviour:
- Reset is asynchronous, active-high, clock is Clock.
  - State goes to IDLE. Read, Write, fault flags and counter go to 0. load_data, Address, Write_data and Func3 go to 0.
  - Reset mid-access drops the strobes immediately; there is no replay.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - With mem_read or mem_write set, stall=1 the same cycle.
  - Latch addr, store_data and func3 into Address, Write_data and Func3.
  - Check the request:
    - Illegal if both mem_read and mem_write are set, if load func3 is not in {000,001,010,100,101}, or if store func3 is not in {000,001,010}.
    - Misaligned: half (001/101) with addr[0]=1; word (010) with addr[1:0]≠00.
  - Illegal or misaligned: go to DONE with fault_misaligned set; no memory strobe is ever driven.
  - Otherwise go to ISSUE.
- ISSUE:
  - Drive Read=mem_read or Write=mem_write for exactly 1 cycle; stall=1.
  - Clear the counter and go to WAIT.
- WAIT:
  - Strobes are 0. Address and Func3 are held stable because the responder reads combinationally. stall=1.
  - busywait=0: capture Read_data into load_data (loads only) and go to DONE.
  - busywait=1: increment the counter. When the counter reaches TIMEOUT_CYCLES-1, go to DONE with fault_timeout set; load_data is unchanged.
- DONE:
  - stall=0; faults are asserted this cycle only; load_data is valid.
  - Pipeline advances on this edge. Go to IDLE.
  - The next request is accepted in IDLE on the following cycle, with no overlap.
- Latency: load or store takes 4 cycles from request (stall high 3 cycles) with busywait low. Fault path takes 2 cycles (stall high 1 cycle).
- Stores never modify load_data.
- load_data holds its last value until the next successful load.
- Pipeline must hold its inputs stable while stall=1. Changes to the inputs after IDLE are ignored.
- A request asserted in DONE is not sampled; it is seen next cycle in IDLE.

Decomposition:
- Shared package cpu_pkg holds:
  - func3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State enum IDLE/ISSUE/WAIT/DONE.
  - TIMEOUT default.
- One natural combinational sub-module, mem_align_check.
  - Inputs: read, write, func3, addr[1:0].
  - Outputs: misaligned, illegal.
  - Reused later by the exception unit.

Test Plan:
- LW addr 0x10, memory word 0xDEADBEEF, busywait=0 → Read high 1 cycle; stall high 3 cycles; load_data=0xDEADBEEF in DONE; no faults.
- SB addr 0x23, store_data 0x000000A5, then LBU 0x23 → Write pulse with Func3=000; load_data=0x000000A5. LB of the same byte gives 0xFFFFFFA5.
- LH addr 0x21 → fault_misaligned pulse in cycle 2; Read and Write never asserted; load_data unchanged. Repeat for SW addr 0x22 and for load func3=011.
- busywait forced high during a LW → stall held 2+16 cycles; fault_timeout pulse; return to IDLE; next LW succeeds.
- Reset asserted during WAIT → Read, Write and stall drop asynchronously; state IDLE; after release a fresh SW 0x40=0x12345678 completes and read-back matches.
- Back-to-back LW/SW with mem_read and mem_write both set in one cycle → fault_misaligned, no strobes; the following legal load completes normally.
